// File: rtl/jpeg_eoi_append.sv
// JPEG output stage: forwards packed 32-bit scan words and appends the EOI marker after each frame.
// Optional frame byte counter enabled with `define JENC_FRAME_SIZE_EN.
module jpeg_eoi_append #(
  parameter logic [15:0] EOI_MARKER = 16'hFFD9
`ifdef JENC_FRAME_SIZE_EN
  ,
  parameter int SIZE_W = 24
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       in_data,
  input  logic              in_tlast,
  input  logic              in_valid,
  output logic              in_hold,
  output logic [31:0]       out_data,
  output logic [2:0]        out_nbytes,
  output logic              out_tlast,
  output logic              out_valid,
  input  logic              out_hold
`ifdef JENC_FRAME_SIZE_EN
  ,
  output logic [SIZE_W-1:0] frame_size,
  output logic              frame_size_vld
`endif
);

  typedef enum logic {ST_PASS, ST_EOI} state_t;

  state_t      state_reg, state_next;
  logic        load;
  logic        take;
  logic [31:0] data_next;
  logic [2:0]  nbytes_next;
  logic        tlast_next;
  logic        valid_next;

  // The output register can be written when empty or when its word leaves this cycle.
  assign load = !out_valid || !out_hold;
  assign take = out_valid && !out_hold;

  always_comb begin
    state_next  = state_reg;
    in_hold     = 1'b1;
    data_next   = out_data;
    nbytes_next = out_nbytes;
    tlast_next  = out_tlast;
    valid_next  = out_valid;
    if (load) valid_next = 1'b0;
    case (state_reg)
      ST_PASS: begin
        in_hold = !load;
        if (in_valid && load) begin
          data_next   = in_data;
          nbytes_next = 3'd4;
          tlast_next  = 1'b0;
          valid_next  = 1'b1;
          if (in_tlast) state_next = ST_EOI;
        end
      end
      ST_EOI: begin
        // Input is stalled for exactly the slot the marker word occupies.
        if (load) begin
          data_next   = {EOI_MARKER, 16'h0000};
          nbytes_next = 3'd2;
          tlast_next  = 1'b1;
          valid_next  = 1'b1;
          state_next  = ST_PASS;
        end
      end
      default: state_next = ST_PASS;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= ST_PASS;
      out_data   <= 32'h0;
      out_nbytes <= 3'd0;
      out_tlast  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      out_data   <= data_next;
      out_nbytes <= nbytes_next;
      out_tlast  <= tlast_next;
      out_valid  <= valid_next;
    end
  end

`ifdef JENC_FRAME_SIZE_EN
  logic [SIZE_W-1:0] count_reg;
  logic [SIZE_W:0]   count_sum;
  logic [SIZE_W-1:0] count_sat;

  assign count_sum = {1'b0, count_reg} + {{(SIZE_W-2){1'b0}}, out_nbytes};
  assign count_sat = count_sum[SIZE_W] ? {SIZE_W{1'b1}} : count_sum[SIZE_W-1:0];

  // The EOI take closes the frame: publish the total and restart from zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg      <= '0;
      frame_size     <= '0;
      frame_size_vld <= 1'b0;
    end else begin
      frame_size_vld <= 1'b0;
      if (take) begin
        if (out_tlast) begin
          frame_size     <= count_sat;
          frame_size_vld <= 1'b1;
          count_reg      <= '0;
        end else begin
          count_reg <= count_sat;
        end
      end
    end
  end
`else
  logic unused_take;
  assign unused_take = take;
`endif

endmodule

// File: tb/tb_jpeg_eoi_append.sv
// Randomized bench for jpeg_eoi_append: scoreboard holds the expected output stream
// (every accepted word, plus one EOI word after each accepted tlast).
module tb_jpeg_eoi_append;

  localparam logic [35:0] EOI_WORD = {32'hFFD90000, 3'd2, 1'b1};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_tlast = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_hold;
  logic [31:0] out_data;
  logic [2:0]  out_nbytes;
  logic        out_tlast;
  logic        out_valid;
  logic        out_hold = 1'b0;
`ifdef JENC_FRAME_SIZE_EN
  logic [23:0] frame_size;
  logic        frame_size_vld;
  int          vld_cnt = 0;
`endif

  jpeg_eoi_append dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_data        (in_data),
    .in_tlast       (in_tlast),
    .in_valid       (in_valid),
    .in_hold        (in_hold),
    .out_data       (out_data),
    .out_nbytes     (out_nbytes),
    .out_tlast      (out_tlast),
    .out_valid      (out_valid),
    .out_hold       (out_hold)
`ifdef JENC_FRAME_SIZE_EN
    ,
    .frame_size     (frame_size),
    .frame_size_vld (frame_size_vld)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          take_cnt = 0;
  int          hold_cnt = 0;
  int          cyc = 0;
  logic [35:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [35:0] prev_word = '0;
  logic [35:0] mon_cur;
  logic [35:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: sampled mid-cycle, inputs are driven just after the rising edge.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      mon_cur = {out_data, out_nbytes, out_tlast};
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_word", mon_cur, prev_word);
      end
      if (out_valid && !out_hold) begin
        take_cnt++;
        $display("take %0d: data=%08h nbytes=%0d tlast=%0b", take_cnt, out_data, out_nbytes, out_tlast);
        check("take_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("out_word", mon_cur, mon_exp);
        end
      end
      if (in_valid && !in_hold) begin
        exp_q.push_back({in_data, 3'd4, 1'b0});
        if (in_tlast) exp_q.push_back(EOI_WORD);
      end
      if (in_valid && in_hold) hold_cnt++;
`ifdef JENC_FRAME_SIZE_EN
      if (frame_size_vld) vld_cnt++;
`endif
      prev_stall = out_valid && out_hold;
      prev_word  = mon_cur;
    end
  end

  // One clock cycle: drive at edge+1, decide acceptance once in_hold has settled.
  task automatic run_cycle(input logic iv, input logic [31:0] d, input logic tl,
                           input logic oh, output logic acc);
    in_valid = iv;
    in_data  = d;
    in_tlast = tl;
    out_hold = oh;
    #1;
    acc = iv && !in_hold;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_word(input logic [31:0] d, input logic tl, input int hold_pct, input int idle_pct);
    logic acc;
    logic oh;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      oh = ($urandom_range(99) < hold_pct);
      if (idle_pct > 0 && $urandom_range(99) < idle_pct)
        run_cycle(1'b0, $urandom, 1'b0, oh, acc);
      else
        run_cycle(1'b1, d, tl, oh, acc);
      n++;
    end
    check("send_accepted", acc, 1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      run_cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
    end
    run_cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", out_valid, 0);
  endtask

  int lens[5];
  int words;
  int t0;
  int c0;
  logic acc_d;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_nbytes", out_nbytes, 0);
    check("reset_tlast", out_tlast, 0);
    check("reset_in_hold", in_hold, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // A,B,C frame with free output
    t0 = take_cnt;
    send_word(32'hA1A2A3A4, 1'b0, 0, 0);
    check("latency_valid", out_valid, 1);
    check("latency_data", out_data, 32'hA1A2A3A4);
    send_word(32'hB1B2B3B4, 1'b0, 0, 0);
    send_word(32'hC1C2C3C4, 1'b1, 0, 0);
    drain();
    check("abc_takes", take_cnt - t0, 4);

    // single-word frame followed immediately by another
    t0 = take_cnt;
    hold_cnt = 0;
    send_word(32'h12FF0034, 1'b1, 0, 0);
    send_word(32'h01020304, 1'b1, 0, 0);
    check("single_hold_cycles", hold_cnt, 1);
    drain();
    check("single_takes", take_cnt - t0, 4);

    // back-to-back frames at full rate
    words = 0;
    foreach (lens[i]) begin
      lens[i] = $urandom_range(6, 1);
      words += lens[i];
    end
    hold_cnt = 0;
    c0 = cyc;
    t0 = take_cnt;
    foreach (lens[i])
      for (int w = 0; w < lens[i]; w++)
        send_word($urandom, (w == lens[i] - 1), 0, 0);
    check("b2b_hold_cycles", hold_cnt, 4);
    check("b2b_cycles", cyc - c0, words + 4);
    drain();
    check("b2b_takes", take_cnt - t0, words + 5);

`ifdef JENC_FRAME_SIZE_EN
    vld_cnt = 0;
    for (int w = 0; w < 5; w++) send_word($urandom, (w == 4), 30, 10);
    drain();
    check("frame_size_5w", frame_size, 22);
    check("frame_vld_count", vld_cnt, 1);
    send_word(32'hFFFFFFFF, 1'b1, 30, 10);
    drain();
    check("frame_size_1w", frame_size, 6);
    check("frame_vld_count2", vld_cnt, 2);
`endif

    // random backpressure and input gaps: 10 frames x 100 words
    t0 = take_cnt;
    for (int f = 0; f < 10; f++)
      for (int w = 0; w < 100; w++)
        send_word($urandom, (w == 99), 50, 25);
    drain();
    check("random_takes", take_cnt - t0, 1010);

    // reset while the EOI is pending and output is stalled
    send_word(32'hAABBCCDD, 1'b1, 0, 0);
    run_cycle(1'b0, 32'h0, 1'b0, 1'b1, acc_d);
    check("pre_reset_valid", out_valid, 1);
    #1;
    resetn = 1'b0;
    #1;
    check("reset_mid_valid", out_valid, 0);
    check("reset_mid_in_hold", in_hold, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    t0 = take_cnt;
    send_word(32'h55667788, 1'b0, 0, 0);
    send_word(32'h99AABBCC, 1'b1, 0, 0);
    drain();
    check("post_reset_takes", take_cnt - t0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
